section3_controller: RTL and testbench

//  Control FSM directly upstream of datapath_section3. Drives its CTRL3/4/5/8/9 selects and enables.

---
 rtl/section3_controller.sv | 157 +++++++++++++++
 tb/tb_section3_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/section3_controller.sv
// section3_controller: control FSM for datapath_section3.
// Runs the m-loop (m=2, then load a1 from the upstream sub operand,
// hold_m=m+1, m=hold_m) until mout >= limit. It uses a start/done handshake
// to the top level and a valid/ready handshake to the sub producer.
// Optional feature: define SECTION3_ITER_COUNT_EN to add the iter_count
// output, which counts accepted sub transfers in the current run.
module section3_controller #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255   // 0 disables the WAIT_SUB timeout
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] mout,
  input  logic             sub_valid,
  output logic             sub_ready,
  output logic             CTRL3,
  output logic             CTRL4,
  output logic             CTRL5,
  output logic             CTRL8,
  output logic             CTRL9,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef SECTION3_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_M, S_CHECK, S_WAIT_SUB, S_INC_M, S_STEP_M, S_DONE, S_ERR
  } state_e;

  // The wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             xfer;

  // A sub operand is consumed only while the controller is waiting for it.
  assign xfer  = sub_valid && (state_q == S_WAIT_SUB);
  assign error = error_q;

  // State and control registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      limit_q    <= '0;
      error_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      error_q    <= error_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic and state-decoded outputs; CTRL8 in WAIT_SUB follows sub_valid.
  // NOTE: every signal gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    error_d    = error_q;
    wait_cnt_d = '0;          // cleared in every state except WAIT_SUB
    sub_ready  = 1'b0;
    CTRL3      = 1'b0;
    CTRL4      = 1'b0;
    CTRL5      = 1'b0;
    CTRL8      = 1'b0;
    CTRL9      = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = limit;
          error_d = 1'b0;
          state_d = S_INIT_M;
        end
      end
      S_INIT_M: begin
        // B=two drives both m and a1.
        CTRL3   = 1'b1;
        CTRL9   = 1'b1;
        CTRL4   = 1'b1;
        CTRL8   = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Unsigned compare; mout already holds the last m write.
        if (mout >= limit_q) state_d = S_DONE;
        else                 state_d = S_WAIT_SUB;
      end
      S_WAIT_SUB: begin
        sub_ready = 1'b1;
        CTRL8     = sub_valid;   // a1 captures sub on the transfer edge
        if (xfer) begin
          state_d = S_INC_M;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_LAST)) begin
          state_d = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_INC_M: begin
        CTRL5   = 1'b1;
        state_d = S_STEP_M;
      end
      S_STEP_M: begin
        // CTRL3=0 selects B=hold_m into m.
        CTRL9   = 1'b1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SECTION3_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;

  assign iter_count = iter_q;

  // Count accepted sub transfers; restart on each accepted start.
  always_comb begin
    iter_d = iter_q;
    if (state_q == S_IDLE && start) iter_d = '0;
    else if (xfer)                  iter_d = iter_q + WIDTH'(1);
  end

  // Transfer counter register.
  always_ff @(posedge CLK) begin
    if (RST) iter_q <= '0;
    else     iter_q <= iter_d;
  end
`endif

endmodule

// File: tb/tb_section3_controller.sv
// Self-checking bench for section3_controller. A behavioural datapath_section3
// closes the m loop; each run pushes its expected outcome to a scoreboard that
// is popped when done pulses. A second instance with TIMEOUT_CYCLES=8 covers
// the timeout path. Define SECTION3_ITER_COUNT_EN to also check iter_count.
module tb_section3_controller;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] mout;
  logic         sub_valid = 1'b0;
  logic         sub_ready, CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, error;

  logic         start2 = 1'b0;
  logic [W-1:0] limit2 = '0;
  logic [W-1:0] mout2  = 16'd2;
  logic         sub_valid2 = 1'b0;
  logic         sub_ready2, c3_2, c4_2, c5_2, c8_2, c9_2, busy2, done2, error2;

`ifdef SECTION3_ITER_COUNT_EN
  logic [W-1:0] iter_count, iter_count2;
`endif

  section3_controller #(.WIDTH(W), .TIMEOUT_CYCLES(255)) dut (
    .CLK(CLK), .RST(RST), .start(start), .limit(limit), .mout(mout),
    .sub_valid(sub_valid), .sub_ready(sub_ready),
    .CTRL3(CTRL3), .CTRL4(CTRL4), .CTRL5(CTRL5), .CTRL8(CTRL8), .CTRL9(CTRL9),
    .busy(busy), .done(done), .error(error)
`ifdef SECTION3_ITER_COUNT_EN
    , .iter_count(iter_count)
`endif
  );

  section3_controller #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut_to (
    .CLK(CLK), .RST(RST), .start(start2), .limit(limit2), .mout(mout2),
    .sub_valid(sub_valid2), .sub_ready(sub_ready2),
    .CTRL3(c3_2), .CTRL4(c4_2), .CTRL5(c5_2), .CTRL8(c8_2), .CTRL9(c9_2),
    .busy(busy2), .done(done2), .error(error2)
`ifdef SECTION3_ITER_COUNT_EN
    , .iter_count(iter_count2)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural datapath_section3 plus sub producer bookkeeping.
  logic [W-1:0] m_r = '0, hold_r = '0, a1_r = '0;
  logic [W-1:0] b_val, sub_data;
  int           xfer_total = 0;
  int           viol = 0;

  assign mout     = m_r;
  assign b_val    = CTRL3 ? 16'd2 : hold_r;
  assign sub_data = 16'h0100 + xfer_total[W-1:0];

  always @(posedge CLK) begin
    if (CTRL9) m_r <= b_val;
    if (CTRL5) hold_r <= m_r + 16'd1;
    if (CTRL8) a1_r <= CTRL4 ? b_val : sub_data;
    if (sub_valid && sub_ready) xfer_total <= xfer_total + 1;
    if (CTRL8 && !CTRL4 && !(sub_valid && sub_ready)) viol <= viol + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic [W-1:0] mout;
    int         iters;
    logic [W-1:0] a1;
    int         x0;
  } exp_t;
  exp_t sb_q[$];

  // Sub producer: withholds sub_valid for 'gap' WAIT_SUB cycles (gap<0: never).
  int wcnt = 0;
  task automatic drive_valid(input int gap);
    if (sub_ready) begin
      sub_valid = (gap >= 0) && (wcnt >= gap);
      wcnt++;
    end else begin
      sub_valid = (gap == 0);
      wcnt = 0;
    end
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, sub_ready};
  endfunction

  // One run: push the expectation, start, watch phases, pop on done.
  task automatic run(input logic [W-1:0] lim, input int gap, input bit poke);
    exp_t e;
    exp_t got;
    int   n;
    int   t;
    n      = (lim > 16'd2) ? int'(lim) - 2 : 0;
    e.lat  = 3 + n * (4 + gap);
    e.mout = (lim > 16'd2) ? lim : 16'd2;
    e.iters = n;
    e.x0   = xfer_total;
    e.a1   = (n > 0) ? 16'h0100 + W'(xfer_total + n - 1) : 16'd2;
    sb_q.push_back(e);

    @(negedge CLK);
    drive_valid(gap);
    start = 1'b1;
    limit = lim;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
      start = poke && (t == 5);       // start while busy must be ignored
      if (poke && t == 5) limit = 16'd3;  // limit change must not matter
      drive_valid(gap);
      #1;
      if (t == 1) check("init_ctrl", ctrl_vec(), 6'b110110);
      if (t == 1) check("init_error_clr", error, 1'b0);
      if (t == 2) check("check_ctrl", ctrl_vec(), 6'b000000);
      if (n > 0 && t == 3) check("wait_ctrl", ctrl_vec(), {3'b000, gap == 0, 2'b01});
      if (n > 0 && t == 4 + gap) check("inc_ctrl", ctrl_vec(), 6'b001000);
      if (n > 0 && t == 5 + gap) check("step_ctrl", ctrl_vec(), 6'b000010);
    end while (!done && t < 2000);

    got = sb_q.pop_front();
    if (done) begin
      check("latency", t, got.lat);
      check("done_busy", busy, 1'b1);
      check("mout", m_r, got.mout);
      check("a1", a1_r, got.a1);
      check("transfers", xfer_total - got.x0, got.iters);
      check("ctrl8_only_on_xfer", viol, 0);
      check("error_low", error, 1'b0);
`ifdef SECTION3_ITER_COUNT_EN
      check("iter_count", iter_count, got.iters);
`endif
    end else begin
      check("done_seen", 1'b0, 1'b1);
    end

    if (poke) begin
      start = 1'b1;                   // pulse during DONE: must be ignored
      @(negedge CLK);
      start = 1'b0;
      #1;
      check("start_in_done_ignored", busy, 1'b0);
    end
    limit = '0;
  endtask

  initial begin
    int t;
    int waits;
    int dones;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_ctrl", ctrl_vec(), 6'b000000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    RST = 1'b0;

    run(16'd5, 0, 1'b0);    // 3 transfers, done at cycle 15
    run(16'd2, 0, 1'b0);    // zero iterations
    run(16'd0, 0, 1'b0);    // zero iterations
    run(16'd3, 0, 1'b0);    // single iteration
    run(16'd4, 10, 1'b0);   // sub_valid withheld 10 cycles per step

    // Reset in INC_M, then a clean run.
    @(negedge CLK);
    drive_valid(0);
    start = 1'b1;
    limit = 16'd5;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
      start = 1'b0;
      drive_valid(0);
      #1;
    end while (!CTRL5 && t < 50);
    check("reached_inc_m", CTRL5, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    check("midrun_rst_ctrl", ctrl_vec(), 6'b000000);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
`ifdef SECTION3_ITER_COUNT_EN
    check("midrun_rst_iter", iter_count, 0);
`endif
    RST = 1'b0;
    run(16'd6, 0, 1'b0);

    run(16'd5, 0, 1'b1);    // start/limit poked while busy and in DONE
    run(16'd7, 3, 1'b0);

    // Timeout instance: sub_valid never arrives.
    @(negedge CLK);
    start2 = 1'b1;
    limit2 = 16'd5;
    t = 0; waits = 0; dones = 0;
    do begin
      @(negedge CLK);
      t++;
      start2 = 1'b0;
      #1;
      if (sub_ready2) waits++;
      if (done2) dones++;
    end while (busy2 && t < 100);
    check("to_idle_cycle", t, 12);
    check("to_wait_cycles", waits, 8);
    check("to_no_done", dones, 0);
    check("to_error_set", error2, 1'b1);
`ifdef SECTION3_ITER_COUNT_EN
    check("to_iter", iter_count2, 0);
`endif

    // A new start clears the sticky error.
    start2 = 1'b1;
    limit2 = 16'd2;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
      start2 = 1'b0;
      #1;
      if (t == 1) check("to_error_cleared", error2, 1'b0);
    end while (!done2 && t < 20);
    check("to_rerun_done", t, 3);
    check("to_rerun_error", error2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
